// File: rtl/clock_divider_multi.sv
// clock_divider_multi: NUM_CH independent runtime-programmable clock dividers.
// Each channel produces a registered divided clock and a period-start tick.
// Configuration is written to a shadow pair and moved to the active pair
// only at a period boundary (or while the channel is disabled).
module clock_divider_multi #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 26,
  parameter int CLK_HZ = 50000000,
  parameter int DEF_HZ = 25000000,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_high,
  output logic [NUM_CH-1:0] cfg_pending,
  output logic [NUM_CH-1:0] div_clk,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(CLK_HZ / DEF_HZ);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [CNT_W-1:0]  div_a  [NUM_CH];
  logic [CNT_W-1:0]  high_a [NUM_CH];
  logic [CNT_W-1:0]  div_s  [NUM_CH];
  logic [CNT_W-1:0]  high_s [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [CNT_W-1:0]  d_eff  [NUM_CH];
  logic [CNT_W-1:0]  h_eff  [NUM_CH];
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] start_ev;
  logic [NUM_CH-1:0] wrap_ev;
  logic [NUM_CH-1:0] apply_now;
  logic [NUM_CH-1:0] wr_hit;

  // Effective period/high-time (clamped so duty is never 0% or 100%) and per-channel events.
  always_comb begin
    start_ev  = '0;
    wrap_ev   = '0;
    apply_now = '0;
    wr_hit    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      d_eff[i] = (div_a[i] < TWO) ? TWO : div_a[i];
      if (high_a[i] == '0)
        h_eff[i] = d_eff[i] >> 1;
      else if (high_a[i] < d_eff[i])
        h_eff[i] = high_a[i];
      else
        h_eff[i] = d_eff[i] - ONE;
      start_ev[i]  = en[i] & (~run[i] | sync);
      wrap_ev[i]   = en[i] & (cnt[i] == (d_eff[i] - ONE));
      // A disabled channel takes its pending shadow on every edge.
      apply_now[i] = cfg_pending[i] & (~en[i] | start_ev[i] | wrap_ev[i]);
      wr_hit[i]    = cfg_we & (32'(cfg_ch) == i);
    end
  end

  // Per-channel config transfer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        div_a[i]  <= DEF_DIV;
        high_a[i] <= '0;
        div_s[i]  <= DEF_DIV;
        high_s[i] <= '0;
        cnt[i]    <= '0;
      end
      run         <= '0;
      cfg_pending <= '0;
      div_clk     <= '0;
      tick        <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (apply_now[i]) begin
          div_a[i]       <= div_s[i];
          high_a[i]      <= high_s[i];
          cfg_pending[i] <= 1'b0;
        end
        // A write on a boundary edge lands in the shadow after the transfer,
        // so it is held for the next boundary with pending left set.
        if (wr_hit[i]) begin
          div_s[i]       <= cfg_div;
          high_s[i]      <= cfg_high;
          cfg_pending[i] <= 1'b1;
        end

        if (!en[i]) begin
          cnt[i]     <= '0;
          run[i]     <= 1'b0;
          div_clk[i] <= 1'b0;
          tick[i]    <= 1'b0;
        end else if (start_ev[i]) begin
          cnt[i]     <= '0;
          run[i]     <= 1'b1;
          tick[i]    <= 1'b1;
          div_clk[i] <= 1'b1;
        end else if (wrap_ev[i]) begin
          cnt[i]     <= '0;
          tick[i]    <= 1'b1;
          div_clk[i] <= 1'b1;
        end else begin
          cnt[i]     <= cnt[i] + ONE;
          tick[i]    <= 1'b0;
          div_clk[i] <= (cnt[i] + ONE) < h_eff[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Testbench for clock_divider_multi: expected per-cycle outputs are queued
// from the period/high-time rule and compared as the DUT advances.
module tb_clock_divider_multi;

  localparam int NCH = 3;
  localparam int CW  = 26;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [NCH-1:0] en = '0;
  logic           sync = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [CW-1:0]  cfg_div = '0;
  logic [CW-1:0]  cfg_high = '0;
  logic [NCH-1:0] cfg_pending;
  logic [NCH-1:0] div_clk;
  logic [NCH-1:0] tick;

  typedef struct {
    string          tag;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] clk_e;
    logic [NCH-1:0] tk_e;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  clock_divider_multi #(
    .NUM_CH(NCH),
    .CNT_W (CW),
    .CLK_HZ(50000000),
    .DEF_HZ(25000000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .sync       (sync),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_high   (cfg_high),
    .cfg_pending(cfg_pending),
    .div_clk    (div_clk),
    .tick       (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=%0d", n_checks, 0);
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected outputs of channel ch over n cycles of a period d, high-time h.
  task automatic push_cycles(input string tag, input int ch, input int d, input int h, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.tag = tag; e.mask = '0; e.clk_e = '0; e.tk_e = '0;
      e.mask[ch]  = 1'b1;
      e.clk_e[ch] = ((k % d) < h);
      e.tk_e[ch]  = ((k % d) == 0);
      sb.push_back(e);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_clk"},  int'(div_clk & e.mask), int'(e.clk_e));
      check({e.tag, "_tick"}, int'(tick & e.mask),    int'(e.tk_e));
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) cycle();
  endtask

  task automatic write_cfg(input int ch, input int dv, input int hi);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = CW'(dv); cfg_high = CW'(hi);
  endtask

  // Program a disabled channel, let it apply, run two periods, disable again.
  task automatic cfg_and_run(input string tag, input int ch, input int dv, input int hi,
                             input int d, input int h);
    write_cfg(ch, dv, hi);
    cycle();
    cfg_we = 1'b0;
    cycle();
    check({tag, "_applied"}, int'(cfg_pending[ch]), 0);
    en[ch] = 1'b1;
    push_cycles(tag, ch, d, h, 2 * d);
    drain();
    en[ch] = 1'b0;
    cycle();
  endtask

  initial begin
    exp_t e;
    // Reset state
    #2 rst_n = 1'b0;
    cycle();
    cycle();
    check("rst_clk",  int'(div_clk), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_pend", int'(cfg_pending), 0);
    rst_n = 1'b1;

    // 1: default divide-by-2 on ch0
    en = 3'b001;
    push_cycles("t1", 0, 2, 1, 6);
    drain();
    en = '0;
    cycle();

    // 2: write ch1 div=5 while enabling; default period runs first
    write_cfg(1, 5, 0);
    en = 3'b010;
    push_cycles("t2_def", 1, 2, 1, 2);
    push_cycles("t2_div5", 1, 5, 2, 10);
    cycle();
    cfg_we = 1'b0;
    check("t2_pend_set", int'(cfg_pending[1]), 1);
    cycle();
    check("t2_pend_hold", int'(cfg_pending[1]), 1);
    cycle();
    check("t2_pend_clr", int'(cfg_pending[1]), 0);
    drain();
    en = '0;
    cycle();

    // 3: ch2 div=10, reprogram to div=4 high=1 mid-period
    write_cfg(2, 10, 0);
    cycle();
    cfg_we = 1'b0;
    check("t3_pend_dis", int'(cfg_pending[2]), 1);
    cycle();
    check("t3_pend_dis_clr", int'(cfg_pending[2]), 0);
    en = 3'b100;
    push_cycles("t3_old", 2, 10, 5, 10);
    push_cycles("t3_new", 2, 4, 1, 8);
    repeat (4) cycle();
    write_cfg(2, 4, 1);
    cycle();
    cfg_we = 1'b0;
    check("t3_pend_set", int'(cfg_pending[2]), 1);
    repeat (5) cycle();
    check("t3_pend_hold", int'(cfg_pending[2]), 1);
    cycle();
    check("t3_pend_clr", int'(cfg_pending[2]), 0);
    drain();
    en = '0;
    cycle();

    // 4: ch0 div=3, ch1 div=7 started out of phase, then sync
    write_cfg(0, 3, 0);
    cycle();
    write_cfg(1, 7, 0);
    cycle();
    cfg_we = 1'b0;
    cycle();
    check("t4_applied", int'(cfg_pending), 0);
    en = 3'b001;
    cycle();
    cycle();
    en = 3'b011;
    cycle();
    cycle();
    sync = 1'b1;
    for (int k = 0; k < 21; k++) begin
      e.tag = "t4_sync"; e.mask = 3'b011; e.clk_e = '0; e.tk_e = '0;
      e.clk_e[0] = ((k % 3) < 1);
      e.tk_e[0]  = ((k % 3) == 0);
      e.clk_e[1] = ((k % 7) < 3);
      e.tk_e[1]  = ((k % 7) == 0);
      sb.push_back(e);
    end
    cycle();
    sync = 1'b0;
    drain();
    // ch0 now sits at cnt=d-1: this write lands on the wrap edge
    write_cfg(0, 2, 0);
    push_cycles("t4_defer", 0, 3, 1, 3);
    push_cycles("t4_defer_new", 0, 2, 1, 4);
    cycle();
    cfg_we = 1'b0;
    check("t4_defer_pend", int'(cfg_pending[0]), 1);
    cycle();
    cycle();
    check("t4_defer_hold", int'(cfg_pending[0]), 1);
    cycle();
    check("t4_defer_clr", int'(cfg_pending[0]), 0);
    drain();
    en = '0;
    cycle();

    // 5: clamping and invalid channel
    cfg_and_run("t5_d1h9", 2, 1, 9, 2, 1);
    cfg_and_run("t5_d0h0", 2, 0, 0, 2, 1);
    cfg_and_run("t5_d6h6", 2, 6, 6, 6, 5);
    write_cfg(3, 9, 0);
    cycle();
    cfg_we = 1'b0;
    check("t5_bad_ch_pend", int'(cfg_pending), 0);
    en = 3'b100;
    push_cycles("t5_bad_ch_keep", 2, 6, 5, 6);
    drain();
    en = '0;
    cycle();

    // 6: enable drop/re-raise, then async reset mid-high phase
    cfg_and_run("t6_cfg", 0, 6, 0, 6, 3);
    en = 3'b001;
    push_cycles("t6_run", 0, 6, 3, 2);
    cycle();
    cycle();
    en = '0;
    e.tag = "t6_drop"; e.mask = 3'b001; e.clk_e = '0; e.tk_e = '0;
    sb.push_back(e);
    cycle();
    en = 3'b001;
    push_cycles("t6_reen", 0, 6, 3, 6);
    drain();
    push_cycles("t6_pre_rst", 0, 6, 3, 2);
    cycle();
    write_cfg(0, 9, 0);
    cycle();
    cfg_we = 1'b0;
    check("t6_pend_before_rst", int'(cfg_pending[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_clk",  int'(div_clk), 0);
    check("t6_rst_tick", int'(tick), 0);
    check("t6_rst_pend", int'(cfg_pending), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en = 3'b111;
    for (int k = 0; k < 6; k++) begin
      e.tag = "t6_def_all"; e.mask = 3'b111;
      e.clk_e = ((k % 2) == 0) ? 3'b111 : 3'b000;
      e.tk_e  = ((k % 2) == 0) ? 3'b111 : 3'b000;
      sb.push_back(e);
    end
    drain();
    en = '0;
    cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
